// File: rtl/p2s_gearbox.sv
// p2s_gearbox: parallel-to-serial gearbox. A one-word holding buffer feeds an
// R-symbol shifter so a new word can load on the same edge the last symbol leaves.
module p2s_gearbox #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic [IN_W-1:0]  idat,
  input  logic             ival,
  input  logic             isop,
  input  logic             ieop,
  output logic             oreq,
  input  logic             ireq,
  output logic [OUT_W-1:0] odat,
  output logic             oval,
  output logic             osop,
  output logic             oeop
);

  // state | meaning
  // IDLE  | shifter empty, nothing presented downstream
  // SHIFT | presenting symbol sym_cnt_q of the word held in sh_dat_q

  localparam int R  = IN_W / OUT_W;
  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] LAST = CW'(R - 1);

  if (((IN_W % OUT_W) != 0) || (R < 2)) begin : g_bad_cfg
    $error("p2s_gearbox: IN_W must be a multiple of OUT_W and IN_W/OUT_W must be >= 2");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   buf_dat_q, buf_dat_d;
  logic              buf_sop_q, buf_sop_d;
  logic              buf_eop_q, buf_eop_d;
  logic              buf_full_q, buf_full_d;
  logic [IN_W-1:0]   sh_dat_q, sh_dat_d;
  logic              sh_sop_q, sh_sop_d;
  logic              sh_eop_q, sh_eop_d;
  logic [CW-1:0]     sym_cnt_q, sym_cnt_d;

  logic              sh_busy;
  logic              consume;
  logic              last_consumed;
  logic              accept;
  logic              load;
  logic [IN_W-1:0]   sh_dat_adv;

  assign sh_busy       = (state_q == SHIFT);
  assign consume       = sh_busy && ireq;
  assign last_consumed = consume && (sym_cnt_q == LAST);
  assign accept        = ival && !buf_full_q;
  assign load          = buf_full_q && (!sh_busy || last_consumed);
  assign sh_dat_adv    = MSB_FIRST ? (sh_dat_q << OUT_W) : (sh_dat_q >> OUT_W);

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q    <= IDLE;
      buf_dat_q  <= '0;
      buf_sop_q  <= 1'b0;
      buf_eop_q  <= 1'b0;
      buf_full_q <= 1'b0;
      sh_dat_q   <= '0;
      sh_sop_q   <= 1'b0;
      sh_eop_q   <= 1'b0;
      sym_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      buf_dat_q  <= buf_dat_d;
      buf_sop_q  <= buf_sop_d;
      buf_eop_q  <= buf_eop_d;
      buf_full_q <= buf_full_d;
      sh_dat_q   <= sh_dat_d;
      sh_sop_q   <= sh_sop_d;
      sh_eop_q   <= sh_eop_d;
      sym_cnt_q  <= sym_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    buf_dat_d  = buf_dat_q;
    buf_sop_d  = buf_sop_q;
    buf_eop_d  = buf_eop_q;
    buf_full_d = buf_full_q;
    sh_dat_d   = sh_dat_q;
    sh_sop_d   = sh_sop_q;
    sh_eop_d   = sh_eop_q;
    sym_cnt_d  = sym_cnt_q;

    // accept needs an empty buffer and load a full one, so they never collide
    if (accept) begin
      buf_dat_d  = idat;
      buf_sop_d  = isop;
      buf_eop_d  = ieop;
      buf_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (load) begin
          sh_dat_d   = buf_dat_q;
          sh_sop_d   = buf_sop_q;
          sh_eop_d   = buf_eop_q;
          sym_cnt_d  = '0;
          buf_full_d = 1'b0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (load) begin
          sh_dat_d   = buf_dat_q;
          sh_sop_d   = buf_sop_q;
          sh_eop_d   = buf_eop_q;
          sym_cnt_d  = '0;
          buf_full_d = 1'b0;
        end else if (last_consumed) begin
          sym_cnt_d = '0;
          state_d   = IDLE;
        end else if (consume) begin
          sh_dat_d  = sh_dat_adv;
          sym_cnt_d = sym_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign oreq = !buf_full_q;
  assign oval = sh_busy;
  assign odat = MSB_FIRST ? sh_dat_q[IN_W-1 -: OUT_W] : sh_dat_q[OUT_W-1:0];
  assign osop = sh_busy && sh_sop_q && (sym_cnt_q == '0);
  assign oeop = sh_busy && sh_eop_q && (sym_cnt_q == LAST);

endmodule

// File: tb/tb_p2s_gearbox.sv
// Bench for p2s_gearbox: an 8->1 MSB-first instance and a 32->8 LSB-first
// instance, each checked symbol by symbol against a queue of expected symbols.
module tb_p2s_gearbox;
  logic iclk = 1'b0;
  always #5 iclk = ~iclk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge iclk) cyc++;

  logic       a_rst, a_val, a_sop, a_eop, a_ireq;
  logic [7:0] a_dat;
  logic       a_oreq, a_oval, a_osop, a_oeop;
  logic [0:0] a_odat;

  logic        b_rst, b_val, b_sop, b_eop, b_ireq;
  logic [31:0] b_dat;
  logic        b_oreq, b_oval, b_osop, b_oeop;
  logic [7:0]  b_odat;

  p2s_gearbox #(.IN_W(8), .OUT_W(1), .MSB_FIRST(1'b1)) u_a (
    .iclk(iclk), .irst(a_rst), .idat(a_dat), .ival(a_val), .isop(a_sop), .ieop(a_eop),
    .oreq(a_oreq), .ireq(a_ireq), .odat(a_odat), .oval(a_oval), .osop(a_osop), .oeop(a_oeop)
  );

  p2s_gearbox #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b0)) u_b (
    .iclk(iclk), .irst(b_rst), .idat(b_dat), .ival(b_val), .isop(b_sop), .ieop(b_eop),
    .oreq(b_oreq), .ireq(b_ireq), .odat(b_odat), .oval(b_oval), .osop(b_osop), .oeop(b_oeop)
  );

  typedef struct {
    logic [7:0] sym;
    logic       sop;
    logic       eop;
  } sym_t;

  typedef struct {
    logic [31:0] dat;
    logic        sop;
    logic        eop;
    logic [7:0]  s0, s1, s2, s3;
  } vec_t;

  sym_t qa[$];
  sym_t qb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  // Instance A monitor: scores consumed symbols, checks hold under backpressure,
  // and expands each accepted word into its 8 expected MSB-first bits.
  int   a_ov_cycles = 0;
  int   a_ov_rises  = 0;
  logic a_prev_oval = 1'b0;
  logic a_hold = 1'b0;
  logic a_hold_dat, a_hold_sop, a_hold_eop;

  always @(negedge iclk) begin
    sym_t e;
    if (a_rst) begin
      qa.delete();
      a_hold = 1'b0;
      a_prev_oval = 1'b0;
    end else begin
      if (a_hold) begin
        check("a_hold_oval", a_oval, 1'b1);
        check("a_hold_odat", a_odat, a_hold_dat);
        check("a_hold_osop", a_osop, a_hold_sop);
        check("a_hold_oeop", a_oeop, a_hold_eop);
      end
      if (a_oval) a_ov_cycles++;
      if (a_oval && !a_prev_oval) a_ov_rises++;
      a_prev_oval = a_oval;
      if (a_oval && a_ireq) begin
        if (qa.size() == 0) begin
          check("a_extra_symbol", 32'd1, 32'd0);
        end else begin
          e = qa.pop_front();
          check("a_odat", a_odat, e.sym);
          check("a_osop", a_osop, e.sop);
          check("a_oeop", a_oeop, e.eop);
        end
      end
      a_hold     = a_oval && !a_ireq;
      a_hold_dat = a_odat[0];
      a_hold_sop = a_osop;
      a_hold_eop = a_oeop;
      if (a_val && a_oreq) begin
        for (int i = 0; i < 8; i++) begin
          e.sym = {7'd0, a_dat[7-i]};
          e.sop = a_sop && (i == 0);
          e.eop = a_eop && (i == 7);
          qa.push_back(e);
        end
      end
    end
  end

  logic       b_hold = 1'b0;
  logic [7:0] b_hold_dat;

  always @(negedge iclk) begin
    sym_t e;
    if (b_rst) begin
      qb.delete();
      b_hold = 1'b0;
    end else begin
      if (b_hold) begin
        check("b_hold_oval", b_oval, 1'b1);
        check("b_hold_odat", b_odat, b_hold_dat);
      end
      if (b_oval && b_ireq) begin
        if (qb.size() == 0) begin
          check("b_extra_symbol", 32'd1, 32'd0);
        end else begin
          e = qb.pop_front();
          check("b_odat", b_odat, e.sym);
          check("b_osop", b_osop, e.sop);
          check("b_oeop", b_oeop, e.eop);
        end
      end
      b_hold     = b_oval && !b_ireq;
      b_hold_dat = b_odat;
    end
  end

  // Holds a_val high until the word is taken; returns the edge count at acceptance.
  task automatic send_a(input logic [7:0] d, input logic s, input logic e, input bit rnd,
                        output int acc_cyc);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    a_dat = d; a_sop = s; a_eop = e; a_val = 1'b1;
    while (!acc && n < 200) begin
      if (rnd) a_ireq = 1'($urandom_range(0, 1));
      acc = a_oreq;
      tick();
      n++;
    end
    acc_cyc = cyc;
    check("a_accept_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic drain_a(input int max_cyc, input bit rnd);
    int n;
    n = 0;
    while ((qa.size() != 0 || a_oval) && n < max_cyc) begin
      a_ireq = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    a_ireq = 1'b1;
    check("a_drain_timeout", {31'd0, (n >= max_cyc)}, 32'd0);
  endtask

  task automatic drain_b(input int max_cyc, input bit rnd);
    int n;
    n = 0;
    while ((qb.size() != 0 || b_oval) && n < max_cyc) begin
      b_ireq = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    b_ireq = 1'b1;
    check("b_drain_timeout", {31'd0, (n >= max_cyc)}, 32'd0);
  endtask

  vec_t tbl[4];

  initial begin
    int t_acc;
    int t_w2, t_w3, t_w4;
    logic [7:0] words[4];
    sym_t e;

    tbl[0] = '{32'h44332211, 1'b1, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44};
    tbl[1] = '{32'hDEADBEEF, 1'b1, 1'b0, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    tbl[2] = '{32'h00FF00FF, 1'b0, 1'b0, 8'hFF, 8'h00, 8'hFF, 8'h00};
    tbl[3] = '{32'h12345678, 1'b0, 1'b1, 8'h78, 8'h56, 8'h34, 8'h12};

    a_rst = 1'b1; a_val = 1'b0; a_sop = 1'b0; a_eop = 1'b0; a_ireq = 1'b1; a_dat = '0;
    b_rst = 1'b1; b_val = 1'b0; b_sop = 1'b0; b_eop = 1'b0; b_ireq = 1'b1; b_dat = '0;

    tick();
    check("rst_a_oval", a_oval, 1'b0);
    check("rst_a_osop", a_osop, 1'b0);
    check("rst_a_oeop", a_oeop, 1'b0);
    check("rst_a_odat", a_odat, 1'b0);
    check("rst_a_oreq", a_oreq, 1'b1);
    check("rst_b_oval", b_oval, 1'b0);
    check("rst_b_odat", b_odat, 8'h00);
    check("rst_b_oreq", b_oreq, 1'b1);
    tick();
    a_rst = 1'b0;
    b_rst = 1'b0;
    tick();

    // single word 0xA5 with sop: one idle cycle in the buffer, then 8 bits
    send_a(8'hA5, 1'b1, 1'b0, 1'b0, t_acc);
    a_val = 1'b0;
    check("lat_a_oval_n1", a_oval, 1'b0);
    check("lat_a_oreq_n1", a_oreq, 1'b0);
    tick();
    check("lat_a_oval_n2", a_oval, 1'b1);
    check("lat_a_odat_n2", a_odat, 1'b1);
    check("lat_a_osop_n2", a_osop, 1'b1);
    drain_a(40, 1'b0);

    // back-to-back stream: contiguous oval, one acceptance every 8 cycles
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03; words[3] = 8'h04;
    a_ov_cycles = 0;
    a_ov_rises  = 0;
    send_a(words[0], 1'b1, 1'b0, 1'b0, t_acc);
    send_a(words[1], 1'b0, 1'b0, 1'b0, t_w2);
    send_a(words[2], 1'b0, 1'b0, 1'b0, t_w3);
    send_a(words[3], 1'b0, 1'b1, 1'b0, t_w4);
    a_val = 1'b0;
    drain_a(80, 1'b0);
    check("stream_first_gap", t_w2 - t_acc, 2);
    check("stream_oreq_gap_w3", t_w3 - t_w2, 8);
    check("stream_oreq_gap_w4", t_w4 - t_w3, 8);
    check("stream_oval_cycles", a_ov_cycles, 32);
    check("stream_oval_bursts", a_ov_rises, 1);

    // random backpressure with 16 random words
    for (int k = 0; k < 16; k++) begin
      send_a(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b1, t_acc);
    end
    a_val = 1'b0;
    drain_a(1000, 1'b1);

    // 32->8 LSB-first table, once at full rate and once with random backpressure
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 4; i++) begin
        int n;
        n = 0;
        b_dat = tbl[i].dat; b_sop = tbl[i].sop; b_eop = tbl[i].eop; b_val = 1'b1;
        while (!b_oreq && n < 100) begin
          if (pass == 1) b_ireq = 1'($urandom_range(0, 1));
          tick();
          n++;
        end
        check("b_accept_timeout", {31'd0, (n >= 100)}, 32'd0);
        e.sym = tbl[i].s0; e.sop = tbl[i].sop; e.eop = 1'b0;        qb.push_back(e);
        e.sym = tbl[i].s1; e.sop = 1'b0;       e.eop = 1'b0;        qb.push_back(e);
        e.sym = tbl[i].s2; e.sop = 1'b0;       e.eop = 1'b0;        qb.push_back(e);
        e.sym = tbl[i].s3; e.sop = 1'b0;       e.eop = tbl[i].eop;  qb.push_back(e);
        if (pass == 1) b_ireq = 1'($urandom_range(0, 1));
        tick();
      end
      b_val = 1'b0;
      drain_b(400, pass == 1);
    end

    // reset mid-word with a second word parked in the buffer
    send_a(8'h5A, 1'b1, 1'b0, 1'b0, t_acc);
    send_a(8'h3C, 1'b0, 1'b1, 1'b0, t_acc);
    a_val = 1'b0;
    tick();
    tick();
    a_rst = 1'b1;
    tick();
    check("midrst_oval", a_oval, 1'b0);
    check("midrst_osop", a_osop, 1'b0);
    check("midrst_oeop", a_oeop, 1'b0);
    check("midrst_odat", a_odat, 1'b0);
    check("midrst_oreq", a_oreq, 1'b1);
    tick();
    a_rst = 1'b0;
    tick();
    check("postrst_idle_oval", a_oval, 1'b0);
    send_a(8'hFF, 1'b1, 1'b1, 1'b0, t_acc);
    a_val = 1'b0;
    check("postrst_lat_n1", a_oval, 1'b0);
    tick();
    check("postrst_lat_n2", a_oval, 1'b1);
    check("postrst_odat", a_odat, 1'b1);
    drain_a(40, 1'b0);

    repeat (3) tick();
    check("a_queue_empty", qa.size(), 0);
    check("b_queue_empty", qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
